// File: rtl/mmio_pkg.sv
// Shared MMIO window constants and the bridge state encoding.
// Peripheral addresses must stay inside MMIO_BASE..16'hFFFF.
package mmio_pkg;

    localparam logic [15:0] MMIO_BASE  = 16'hFF00;
    localparam logic [15:0] LED_ADDR   = 16'hFF00;
    localparam logic [15:0] UART_ADDR  = 16'hFF10;
    localparam logic [15:0] TIMER_ADDR = 16'hFF20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } mmio_state_e;

endpackage

// File: rtl/mmio_timeout_counter.sv
// WAIT-phase watchdog: clears on entry to WAIT, counts WAIT cycles without a done.
// terminal is high in the WAIT cycle whose increment would reach LIMIT.
module mmio_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = enable && (count_q == LAST);

endmodule

// File: rtl/mmio_bridge.sv
// CPU-to-MMIO bridge: out-of-window accesses complete with error, others run REQ/WAIT/RESP.
// Latency: 1 cycle for errors, 2 + peripheral response cycles otherwise; cpu_req is ignored while busy.
// Define MMIO_TIMEOUT_EN to bound WAIT at TIMEOUT_CYCLES with an error completion.
module mmio_bridge #(
    parameter logic [15:0] MMIO_BASE      = mmio_pkg::MMIO_BASE,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic        cpu_ready,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_error,
    output logic        busy,
    output logic [15:0] mmio_addr,
    output logic [7:0]  mmio_data,
    output logic        mmio_we,
    output logic        mmio_req,
    input  logic        mmio_done,
    input  logic [7:0]  mmio_rdata
);

    import mmio_pkg::*;

    mmio_state_e state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        we_q, we_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        error_q, error_d;

`ifdef MMIO_TIMEOUT_EN
    logic tmo_clear, tmo_enable, tmo_expired;

    mmio_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (tmo_clear),
        .enable   (tmo_enable),
        .terminal (tmo_expired)
    );
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        error_d = error_q;
`ifdef MMIO_TIMEOUT_EN
        tmo_clear  = 1'b0;
        tmo_enable = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (cpu_addr >= MMIO_BASE) begin
                        addr_d  = cpu_addr;
                        data_d  = cpu_wdata;
                        we_d    = cpu_we;
                        state_d = ST_REQ;
                    end else begin
                        rdata_d = '0;
                        error_d = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
`ifdef MMIO_TIMEOUT_EN
                tmo_clear = 1'b1;
`endif
            end
            ST_WAIT: begin
                // A done in the same cycle as expiry still wins.
                if (mmio_done) begin
                    rdata_d = we_q ? 8'h00 : mmio_rdata;
                    error_d = 1'b0;
                    state_d = ST_RESP;
                end
`ifdef MMIO_TIMEOUT_EN
                else begin
                    tmo_enable = 1'b1;
                    if (tmo_expired) begin
                        rdata_d = '0;
                        error_d = 1'b1;
                        state_d = ST_RESP;
                    end
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    assign mmio_req  = (state_q == ST_REQ);
    assign cpu_ready = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign mmio_addr = addr_q;
    assign mmio_data = data_q;
    assign mmio_we   = we_q;
    assign cpu_rdata = rdata_q;
    assign cpu_error = error_q;

endmodule

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 Parameter MMIO_BASE, 16'hFF00, lowest address in the MMIO window; the window spans MMIO_BASE..16'hFFFF.
REQ-002 Parameter TIMEOUT_CYCLES, 255, maximum WAIT cycles before an error completion (range 1..65535).
REQ-003 Port clock  in  1  rising-edge clock.
REQ-004 Port reset  in  1  reset, synchronous, active-high.
REQ-005 Port cpu_req  in  1  CPU access request, sampled only in IDLE.
REQ-006 Port cpu_addr  in  16  CPU access address.
REQ-007 Port cpu_wdata  in  8  CPU write data.
REQ-008 Port cpu_we  in  1  1 = write, 0 = read.
REQ-009 Port cpu_ready  out  1  one-cycle completion pulse.
REQ-010 Port cpu_rdata  out  8  read data, valid while cpu_ready=1.
REQ-011 Port cpu_error  out  1  error flag, valid while cpu_ready=1.
REQ-012 Port busy  out  1  high in every state except IDLE.
REQ-013 Port mmio_addr  out  16  peripheral address, latched.
REQ-014 Port mmio_data  out  8  peripheral write data, latched.
REQ-015 Port mmio_we  out  1  peripheral write strobe qualifier, latched.
REQ-016 Port mmio_req  out  1  one-cycle request pulse to peripherals.
REQ-017 Port mmio_done  in  1  OR of all peripheral done pulses.
REQ-018 Port mmio_rdata  in  8  OR of peripheral read data, sampled with mmio_done.

Function
REQ-019 The FSM SHALL have the states IDLE, REQ, WAIT and RESP.
REQ-020 IDLE: on cpu_req=1 with cpu_addr>=MMIO_BASE, latch addr/wdata/we into mmio_addr/mmio_data/mmio_we and go to REQ.
REQ-021 IDLE: on cpu_req=1 with cpu_addr<MMIO_BASE, go to RESP with error=1 and rdata=0; no mmio_req is issued.
REQ-022 REQ: mmio_req=1 for exactly one cycle, then go to WAIT unconditionally.
REQ-023 WAIT: on mmio_done=1, capture mmio_rdata (capture 0 if mmio_we=1), set error=0, go to RESP.
REQ-024 RESP: cpu_ready=1 for one cycle with the captured rdata/error, then go to IDLE.
REQ-025 mmio_addr, mmio_data and mmio_we SHALL hold stable from REQ through RESP.
REQ-026 mmio_done outside WAIT, including during the REQ cycle, SHALL be ignored.
REQ-027 cpu_req while not in IDLE SHALL be ignored; it is not queued.
REQ-028 Latency for a peripheral answering one cycle after mmio_req: cpu_ready is asserted 3 cycles after the cycle in which cpu_req is sampled.
REQ-029 Back-to-back: cpu_req held high is accepted again in the IDLE cycle that follows RESP.
REQ-030 cpu_rdata and cpu_error SHALL hold their last values outside RESP.

Reset
REQ-031 Reset SHALL force IDLE and clear mmio_req, cpu_ready, cpu_error, busy, cpu_rdata, mmio_addr, mmio_data and mmio_we to 0, and the timeout counter to 0.
REQ-032 Reset asserted mid-transaction SHALL abort it without a cpu_ready pulse; a late mmio_done after reset SHALL be ignored.

Configuration
REQ-033 With MMIO_TIMEOUT_EN defined: a counter SHALL clear on entry to WAIT and increment each WAIT cycle without mmio_done; on reaching TIMEOUT_CYCLES the FSM goes to RESP with error=1 and rdata=0.
REQ-034 Without MMIO_TIMEOUT_EN: WAIT SHALL persist until mmio_done, no counter logic is present, and error is raised only by an out-of-window address.

Structure
REQ-035 The state enum typedef and the MMIO window constants (MMIO_BASE and the peripheral addresses, including LED) SHALL live in shared package mmio_pkg.
REQ-036 The timeout counter SHALL be the sub-module mmio_timeout_counter (clear, enable, terminal-count output) and is instantiated only under MMIO_TIMEOUT_EN.

Verification
REQ-037 Write 0xFF00 data 0x2A, stub peripheral answers done one cycle after mmio_req -> single-cycle mmio_req, mmio_data=0x2A, cpu_ready 3 cycles after request, error=0.
REQ-038 Read 0xFF10, stub answers done with rdata=0x5C -> cpu_rdata=0x5C, cpu_error=0.
REQ-039 Read 0x1234 -> no mmio_req, cpu_ready 1 cycle after request, cpu_error=1, cpu_rdata=0.
REQ-040 MMIO_TIMEOUT_EN, TIMEOUT_CYCLES=4, peripheral never answers -> cpu_ready with error=1 after 4 WAIT cycles; without the macro -> busy stays high indefinitely.
REQ-041 Reset pulsed during WAIT, then mmio_done pulsed -> no cpu_ready, FSM in IDLE, all outputs 0.
REQ-042 cpu_req held high for 10 cycles with a one-cycle-done stub -> one transaction per 4-cycle window, no overlap, stray mmio_done during REQ ignored.
